// File: rtl/mont_exp_ctrl.sv
// Montgomery-domain modular exponentiation sequencer driving one external
// multiplier over start/done/out_read with square-and-always-multiply.
module mont_exp_ctrl #(
   parameter int unsigned WIDTH     = 381,
   parameter int unsigned EXP_WIDTH = 381,
   parameter int unsigned CNT_W     = 9
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     in_base,
   input  logic [EXP_WIDTH-1:0] in_exp,
   input  logic [WIDTH-1:0]     in_one,
   input  logic [WIDTH-1:0]     in_m,
   input  logic                 out_read,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     result,
   output logic                 mm_start,
   output logic [WIDTH-1:0]     mm_in_a,
   output logic [WIDTH-1:0]     mm_in_b,
   output logic [WIDTH-1:0]     mm_in_m,
   output logic                 mm_out_read,
   input  logic [WIDTH-1:0]     mm_result,
   input  logic                 mm_done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_ACK   = 3'd4;
   localparam logic [2:0] S_GAP1  = 3'd5;
   localparam logic [2:0] S_GAP2  = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   localparam logic PH_SQ  = 1'b0;
   localparam logic PH_MUL = 1'b1;

   logic [2:0]           state, state_nxt;
   logic                 phase, phase_nxt;
   logic [CNT_W-1:0]     idx, idx_nxt;
   logic [WIDTH-1:0]     acc, acc_nxt;
   logic [WIDTH-1:0]     base_reg, base_nxt;
   logic [WIDTH-1:0]     m_reg, m_nxt;
   logic [EXP_WIDTH-1:0] exp_reg, exp_nxt;
   logic                 busy_nxt, done_nxt, mm_start_nxt, mm_out_read_nxt;
   logic [WIDTH-1:0]     result_nxt, mm_in_a_nxt, mm_in_b_nxt, mm_in_m_nxt;

   // State and every output/datapath register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         phase       <= PH_SQ;
         idx         <= '0;
         acc         <= '0;
         base_reg    <= '0;
         m_reg       <= '0;
         exp_reg     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         mm_start    <= 1'b0;
         mm_out_read <= 1'b0;
         mm_in_a     <= '0;
         mm_in_b     <= '0;
         mm_in_m     <= '0;
      end else begin
         state       <= state_nxt;
         phase       <= phase_nxt;
         idx         <= idx_nxt;
         acc         <= acc_nxt;
         base_reg    <= base_nxt;
         m_reg       <= m_nxt;
         exp_reg     <= exp_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         result      <= result_nxt;
         mm_start    <= mm_start_nxt;
         mm_out_read <= mm_out_read_nxt;
         mm_in_a     <= mm_in_a_nxt;
         mm_in_b     <= mm_in_b_nxt;
         mm_in_m     <= mm_in_m_nxt;
      end
   end

   // Next state, datapath updates and registered-output decode.
   always_comb begin
      state_nxt   = state;
      phase_nxt   = phase;
      idx_nxt     = idx;
      acc_nxt     = acc;
      base_nxt    = base_reg;
      m_nxt       = m_reg;
      exp_nxt     = exp_reg;
      result_nxt  = result;
      mm_in_a_nxt = mm_in_a;
      mm_in_b_nxt = mm_in_b;
      mm_in_m_nxt = mm_in_m;

      case (state)
         S_IDLE: begin
            if (start) begin
               base_nxt  = in_base;
               exp_nxt   = in_exp;
               m_nxt     = in_m;
               acc_nxt   = in_one;
               idx_nxt   = CNT_W'(EXP_WIDTH - 1);
               phase_nxt = PH_SQ;
               state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            mm_in_a_nxt = acc;
            mm_in_b_nxt = (phase == PH_MUL) ? base_reg : acc;
            mm_in_m_nxt = m_reg;
            state_nxt   = S_ISSUE;
         end
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (mm_done) state_nxt = S_ACK;
         end
         S_ACK: begin
            // The multiply product is always computed but only kept for a 1 bit.
            if ((phase == PH_SQ) || exp_reg[idx]) acc_nxt = mm_result;
            state_nxt = S_GAP1;
         end
         S_GAP1: state_nxt = S_GAP2;
         S_GAP2: begin
            if (phase == PH_SQ) begin
               phase_nxt = PH_MUL;
               state_nxt = S_SETUP;
            end else if (idx != '0) begin
               idx_nxt   = idx - CNT_W'(1);
               phase_nxt = PH_SQ;
               state_nxt = S_SETUP;
            end else begin
               result_nxt = acc;
               state_nxt  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_read) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      mm_start_nxt    = (state_nxt == S_ISSUE);
      mm_out_read_nxt = (state_nxt == S_ACK);
      busy_nxt        = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done_nxt        = (state_nxt == S_DONE);
   end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: bit-serial Montgomery multiplier model with
// variable latency, operand/result scoreboards and protocol timing checks.
module tb_mont_exp_ctrl;

   localparam int unsigned W       = 381;
   localparam int unsigned EW      = 381;
   localparam int unsigned FIX_LAT = 5;
   localparam int unsigned BUDGET  = 2 * EW * 410 + 100;
   localparam logic [W-1:0] MOD =
      381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } op_t;

   logic          clk = 1'b0;
   logic          reset, start, out_read, mm_done;
   logic [W-1:0]  in_base, in_one, in_m, mm_result;
   logic [EW-1:0] in_exp;
   logic          busy, done, mm_start, mm_out_read;
   logic [W-1:0]  result, mm_in_a, mm_in_b, mm_in_m;

   int            n_vec = 0;
   int            n_err = 0;
   op_t           op_q[$];
   logic [W-1:0]  res_q[$];
   logic [W-1:0]  base_v, one_v;
   int            cyc_zero;

   always #5 clk = ~clk;

   mont_exp_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .in_base(in_base), .in_exp(in_exp),
      .in_one(in_one), .in_m(in_m), .out_read(out_read), .busy(busy), .done(done),
      .result(result), .mm_start(mm_start), .mm_in_a(mm_in_a), .mm_in_b(mm_in_b),
      .mm_in_m(mm_in_m), .mm_out_read(mm_out_read), .mm_result(mm_result),
      .mm_done(mm_done)
   );

   // a*b*2^-W mod m, bit-serial.
   function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] m);
      logic [W+1:0] t;
      t = '0;
      for (int i = 0; i < int'(W); i++) begin
         if (a[i]) t = t + {2'b00, b};
         if (t[0]) t = t + {2'b00, m};
         t = t >> 1;
      end
      if (t >= {2'b00, m}) t = t - {2'b00, m};
      return t[W-1:0];
   endfunction

   function automatic logic [383:0] rand384();
      logic [383:0] v;
      for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Golden square-and-always-multiply: fills the expected operand queue.
   task automatic build_ops(input logic [EW-1:0] e, output logic [W-1:0] res);
      logic [W-1:0] acc, p;
      op_q.delete();
      acc = one_v;
      for (int i = int'(EW) - 1; i >= 0; i--) begin
         op_q.push_back('{a: acc, b: acc});
         acc = mont(acc, acc, MOD);
         op_q.push_back('{a: acc, b: base_v});
         p = mont(acc, base_v, MOD);
         if (e[i]) acc = p;
      end
      res = acc;
   endtask

   // One exponentiation with the bench acting as the multiplier.
   task automatic run_exp(input logic [EW-1:0] e, input int lat_mode, input int rst_op,
                          input bit poke, output int cycles);
      logic [W-1:0] dummy, op_a, op_b, op_m, exp_res;
      op_t          eo;
      int           lat_left, n_ops, since_ack;
      bit           active, rst_arm, stop, aborted;
      build_ops(e, dummy);
      @(negedge clk);
      in_base = base_v; in_exp = e; in_one = one_v; in_m = MOD; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_base = W'(rand384()); in_exp = ~e; in_one = '0; in_m = W'(rand384());
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_start: got %b want 1", busy); end
      cycles = 0; n_ops = 0; since_ack = 100; lat_left = 0;
      active = 1'b0; rst_arm = 1'b0; stop = 1'b0; aborted = 1'b0;
      op_a = '0; op_b = '0; op_m = '0;
      while (!stop) begin
         if (rst_arm) begin
            reset = 1'b1; mm_done = 1'b0; active = 1'b0; start = 1'b0; out_read = 1'b0;
            @(negedge clk);
            n_vec++;
            if ({busy, done, mm_start, mm_out_read} !== 4'b0000 || result !== '0) begin
               n_err++;
               $display("FAIL reset_mid_op: got busy/done/start/read=%b%b%b%b want 0000",
                        busy, done, mm_start, mm_out_read);
            end
            reset = 1'b0;
            aborted = 1'b1;
            stop = 1'b1;
         end else if (done === 1'b1) begin
            stop = 1'b1;
         end else begin
            since_ack++;
            if (mm_out_read === 1'b1) begin
               n_vec++;
               if (!(active && mm_done === 1'b1)) begin
                  n_err++; $display("FAIL mm_out_read_pulse: got 1 at op %0d want 0", n_ops);
               end
               mm_done = 1'b0; active = 1'b0; since_ack = 0;
            end
            if (mm_start === 1'b1) begin
               n_vec++;
               if (active) begin n_err++; $display("FAIL mm_start_pulse: got 1 while busy at op %0d want 0", n_ops); end
               n_vec++;
               if (since_ack < 4) begin
                  n_err++; $display("FAIL ack_to_start_gap: got %0d want >=4", since_ack);
               end
               n_vec++;
               if (op_q.size() == 0) begin
                  n_err++; $display("FAIL op_count: got extra mm_start at op %0d want none", n_ops);
               end else begin
                  eo = op_q.pop_front();
                  if (mm_in_a !== eo.a || mm_in_b !== eo.b || mm_in_m !== MOD) begin
                     n_err++;
                     $display("FAIL operands op %0d: got a=%h b=%h want a=%h b=%h",
                              n_ops, mm_in_a, mm_in_b, eo.a, eo.b);
                  end
               end
               op_a = mm_in_a; op_b = mm_in_b; op_m = mm_in_m;
               active = 1'b1; mm_done = 1'b0; n_ops++;
               if (lat_mode == 0) lat_left = int'(FIX_LAT);
               else if (n_ops % 32 == 0) lat_left = int'($urandom_range(400, 1));
               else lat_left = int'($urandom_range(4, 1));
               if (n_ops == rst_op) rst_arm = 1'b1;
            end else if (active && mm_done !== 1'b1) begin
               n_vec++;
               if (mm_in_a !== op_a || mm_in_b !== op_b || mm_in_m !== op_m) begin
                  n_err++; $display("FAIL operand_stability op %0d: got a=%h want a=%h", n_ops, mm_in_a, op_a);
               end
               lat_left--;
               if (lat_left == 0) begin
                  mm_result = mont(op_a, op_b, op_m);
                  mm_done   = 1'b1;
               end
            end
            start    = poke && n_ops == 5 && active && mm_done !== 1'b1;
            out_read = poke && n_ops == 7 && active;
            @(negedge clk);
            cycles++;
            if (cycles > int'(BUDGET)) begin
               n_vec++; n_err++;
               $display("FAIL timeout: got no done after %0d cycles want done", cycles);
               reset = 1'b1; @(negedge clk); reset = 1'b0;
               aborted = 1'b1; stop = 1'b1;
            end
         end
      end
      start = 1'b0; out_read = 1'b0; mm_done = 1'b0;
      op_q.delete();
      exp_res = (res_q.size() != 0) ? res_q.pop_front() : '0;
      if (!aborted) begin
         n_vec++;
         if (n_ops != int'(2 * EW)) begin n_err++; $display("FAIL op_count: got %0d want %0d", n_ops, 2 * EW); end
         n_vec++;
         if (busy !== 1'b0) begin n_err++; $display("FAIL busy_in_done: got %b want 0", busy); end
         n_vec++;
         if (result !== exp_res) begin n_err++; $display("FAIL result: got %h want %h", result, exp_res); end
         if (poke) begin
            start = 1'b1; @(negedge clk); start = 1'b0;
            for (int i = 0; i < 50; i++) begin
               @(negedge clk);
               n_vec++;
               if (done !== 1'b1 || busy !== 1'b0 || mm_start !== 1'b0 || result !== exp_res) begin
                  n_err++;
                  $display("FAIL done_hold cycle %0d: got done=%b busy=%b mm_start=%b want 1 0 0",
                           i, done, busy, mm_start);
               end
            end
         end
         out_read = 1'b1; @(negedge clk); out_read = 1'b0;
         n_vec++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL release: got done=%b busy=%b want 0 0", done, busy);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++;
      if ({busy, done, mm_start, mm_out_read} !== 4'b0000 || result !== '0 ||
          mm_in_a !== '0 || mm_in_b !== '0 || mm_in_m !== '0) begin
         n_err++; $display("FAIL reset_values: got busy/done/start/read=%b%b%b%b want 0000",
                           busy, done, mm_start, mm_out_read);
      end
      reset = 1'b0;
      out_read = 1'b1;
      repeat (3) @(negedge clk);
      out_read = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || mm_start !== 1'b0) begin
         n_err++; $display("FAIL idle_after_reset: got busy=%b done=%b mm_start=%b want 0 0 0", busy, done, mm_start);
      end
   endtask

   task automatic test_exp_zero();
      res_q.push_back(one_v);
      run_exp('0, 0, -1, 1'b0, cyc_zero);
      n_vec++;
      if (cyc_zero != int'(2 * EW * (5 + FIX_LAT))) begin
         n_err++; $display("FAIL cycle_count_zero: got %0d want %0d", cyc_zero, 2 * EW * (5 + FIX_LAT));
      end
   endtask

   task automatic test_exp_one();
      int c;
      res_q.push_back(base_v);
      run_exp(EW'(1), 1, -1, 1'b0, c);
   endtask

   task automatic test_ignored_inputs();
      int c;
      res_q.push_back(mont(base_v, base_v, MOD));
      run_exp(EW'(2), 1, -1, 1'b1, c);
   endtask

   task automatic test_constant_time();
      int           c;
      logic [W-1:0] gold;
      build_ops('1, gold);
      res_q.push_back(gold);
      run_exp('1, 0, -1, 1'b0, c);
      n_vec++;
      if (c != cyc_zero) begin n_err++; $display("FAIL constant_time: got %0d want %0d", c, cyc_zero); end
   endtask

   task automatic test_random_latency();
      int            c;
      logic [W-1:0]  gold;
      logic [EW-1:0] e;
      e = EW'(rand384());
      build_ops(e, gold);
      res_q.push_back(gold);
      run_exp(e, 1, -1, 1'b0, c);
   endtask

   task automatic test_reset_mid_op();
      int            c;
      logic [W-1:0]  gold;
      logic [EW-1:0] e;
      res_q.push_back('0);
      run_exp(EW'(rand384()), 1, 100, 1'b0, c);
      e = EW'(rand384());
      build_ops(e, gold);
      res_q.push_back(gold);
      run_exp(e, 1, -1, 1'b0, c);
   endtask

   initial begin
      logic [W:0] r;
      reset = 1'b1; start = 1'b0; out_read = 1'b0; mm_done = 1'b0; mm_result = '0;
      in_base = '0; in_exp = '0; in_one = '0; in_m = '0;
      r = {1'b1, {W{1'b0}}};
      one_v = W'(r - {1'b0, MOD});
      base_v = W'(rand384());
      base_v[W-1] = 1'b0;
      test_reset();
      test_exp_zero();
      test_exp_one();
      test_ignored_inputs();
      test_constant_time();
      test_random_latency();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
